adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
Synthesizable SPI responder that emulates the on-board 8-channel 12-bit serial ADC (ADC128S022-style framing) on the far end of the existing ADC_CTRL master. Used for hardware-in-the-loop and bench tests: fabric logic feeds per-channel sample words (e.g. synthetic depth or pressure values), and the master reads them exactly as it would read the real ADC. All SPI pins are oversampled on a single system clock.

Parameters:
DATA_W, 12, sample width per channel.
N_CH, 8, number of channels; the address width is 3.
SYNC_STAGES, 2, synchronizer depth on iSCLK, iCS_n and iDIN.

Ports:
iCLK  in  1  system clock; must be at least 8x the iSCLK frequency.
iRST  in  1  asynchronous, active-high reset.
iCS_n  in  1  chip select from the master, active low.
iSCLK  in  1  SPI clock from the master; idles high.
iDIN  in  1  master address bits (maps to the master's oDIN).
iCH_DATA  in  N_CH*DATA_W  sample words; channel k occupies bits [k*DATA_W +: DATA_W].
oDOUT  out  1  serial data to the master (maps to the master's iDOUT).
oDOUT_OE  out  1  output enable; high while the synchronized CS_n is low.
oFRAME_DONE  out  1  one-cycle pulse when a full 16-bit frame completes.
oCH  out  3  channel whose word the current frame is shifting.
oADDR_NEXT  out  3  address captured during the last completed frame.

Behaviour:
- Reset values: all outputs are 0. The bit index is 0, the shift register is 0, and the FSM is in IDLE.
- Synchronization: each input passes through SYNC_STAGES flops. Edges are detected on the synchronized signals by comparing against a one-flop delayed copy.
- Latency: oDOUT updates 1 iCLK cycle after the falling edge is detected, which is SYNC_STAGES+1 iCLK cycles after the pin edge.
- FSM IDLE: oDOUT_OE=0 and oDOUT=0.
  - On a CS_n falling edge: index=0, oCH=0, latch word = iCH_DATA[ch 0], oDOUT=0, go to ACTIVE.
- FSM ACTIVE, SCLK falling edge: index = index+1 mod 16. oDOUT is driven from the new index:
  - index 0-3: oDOUT=0 (leading zeros).
  - index 4-15: oDOUT = word[15-index], i.e. DB11 down to DB0, MSB first.
- FSM ACTIVE, SCLK rising edge:
  - At index 3, 4 and 5, shift iDIN into addr_shift as ADD2, ADD1, ADD0.
  - At index 15 the frame is complete:
    - oADDR_NEXT <= addr_shift; pulse oFRAME_DONE.
    - Load the next word from iCH_DATA[addr_shift] and set oCH <= addr_shift.
    - The next falling edge wraps the index to 0 and outputs the leading zero of the new frame.
- Word latching: the word is latched only at frame start (CS fall or commit). Changes on iCH_DATA mid-frame never tear the word being shifted.
- CS_n rising edge:
  - Takes effect immediately, aborting any partial frame.
  - Go to IDLE; oDOUT_OE=0; oADDR_NEXT keeps its value.
  - A partially captured address is discarded. oFRAME_DONE is not pulsed.
  - The next CS fall always starts on channel 0.
- Simultaneous events:
  - CS rise in the same cycle as an SCLK edge: CS wins and the edge is ignored.
  - SCLK edges while in IDLE are ignored.
- Reset asserted mid-frame: immediate return to reset values. A transfer that is already underway is not resumed after reset releases; the bench must wait for a fresh CS fall.
- Unused channel indices (only possible if N_CH < 8): the responder returns 0.

Optional Feature:
ADC_RESP_PATTERN_EN
- Defined: iCH_DATA is ignored. The latched word is {channel[2:0], frame_cnt[DATA_W-4:0]}, where frame_cnt is a free-running counter that increments on each oFRAME_DONE, resets to 0 and wraps. This gives self-checking traffic without a data source.
- Undefined: the counter and the pattern mux are not compiled in; words come from iCH_DATA.

Decomposition:
- Package adc_resp_pkg holds:
  - localparams FRAME_BITS=16, LEAD_ZEROS=4, ADDR_LO_IDX=3, ADDR_HI_IDX=5, ADDR_W=3.
  - FSM state enum {IDLE, ACTIVE}.
- One sub-module, adc_resp_sync_edge: parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs. It is instantiated three times: iSCLK, iCS_n and iDIN, the last without edge outputs.

Test Plan:
- Single frame: CS fall, iCH_DATA ch0=12'hA5C, DIN=0, 16 SCLK pulses at iCLK/10. Required response: the master samples 0000_1010_0101_1100, then oFRAME_DONE=1 for one cycle and oADDR_NEXT=0.
- Address sequencing: continuous CS low; DIN sends addresses 5, then 2, then 7; ch5=12'h123, ch2=12'hFFF, ch7=12'h001. Required response: frames 2-4 return 123, FFF, 001, and oCH follows 0, 5, 2, 7.
- Abort: CS rises after 9 SCLK pulses. Required response: oDOUT_OE=0 within SYNC_STAGES+1 cycles, no oFRAME_DONE, and the next frame after a new CS fall returns ch0.
- Tear-free: change ch0 from 12'h0F0 to 12'h800 at index 7. Required response: the current frame still returns 0F0.
- Reset mid-frame: assert iRST at index 10. Required response: all outputs are 0 on the same edge, and after release plus a new CS fall the frame starts at index 0.
- Pattern build (ADC_RESP_PATTERN_EN): 3 frames with address 3. Required response: words 0x000 (ch0, frame_cnt=0), then 0x601 and 0x602 (ch3, frame_cnt=1 and 2).

Source files
------------

// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared frame geometry and FSM states for the ADC SPI responder.
package adc_resp_pkg;
   localparam int FRAME_BITS = 16;
   localparam int LEAD_ZEROS = 4;
   localparam int ADDR_LO_IDX = 3;
   localparam int ADDR_HI_IDX = 5;
   localparam int ADDR_W = 3;
   typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/adc_resp_sync_edge.sv
// adc_resp_sync_edge: multi-flop synchronizer with optional rise/fall pulses.
module adc_resp_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGES = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sr;
   logic dly;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr <= '0;
         dly <= 1'b0;
      end else begin
         sr <= {sr[SYNC_STAGES-2:0], d};
         dly <= sr[SYNC_STAGES-1];
      end
   assign q = sr[SYNC_STAGES-1];
   assign rise = EDGES && q && !dly;
   assign fall = EDGES && !q && dly;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: oversampled SPI responder emulating an 8-channel 12-bit serial ADC.
// Define ADC_RESP_PATTERN_EN to replace iCH_DATA with a {channel, frame_cnt} test pattern.
module adc_spi_responder
   import adc_resp_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int N_CH = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iCS_n,
   input  logic                   iSCLK,
   input  logic                   iDIN,
   input  logic [N_CH*DATA_W-1:0] iCH_DATA,
   output logic                   oDOUT,
   output logic                   oDOUT_OE,
   output logic                   oFRAME_DONE,
   output logic [ADDR_W-1:0]      oCH,
   output logic [ADDR_W-1:0]      oADDR_NEXT
);
   logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;
   logic sclk_q_unused, cs_q_unused;
   logic [1:0] din_edges_unused;
   state_t state, state_n;
   logic [3:0] idx, idx_n, bit_sel;
   logic [DATA_W-1:0] word, word_n, load_word;
   logic [ADDR_W-1:0] addr_sh, addr_sh_n, ch_n, addr_next_n, load_ch;
   logic dout_n, start, commit;

   adc_resp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
      .clk(iCLK), .rst(iRST), .d(iSCLK), .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));
   adc_resp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
      .clk(iCLK), .rst(iRST), .d(iCS_n), .q(cs_q_unused), .rise(cs_rise), .fall(cs_fall));
   adc_resp_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGES(1'b0)) u_din (
      .clk(iCLK), .rst(iRST), .d(iDIN), .q(din_s), .rise(din_edges_unused[1]), .fall(din_edges_unused[0]));

   // A CS rise pre-empts any SCLK edge seen in the same cycle.
   assign start = (state == IDLE) && cs_fall;
   assign commit = (state == ACTIVE) && !cs_rise && sclk_rise && (idx == 4'(FRAME_BITS-1));
   assign load_ch = commit ? addr_sh : '0;
   assign idx_n = idx + 4'd1;
   assign bit_sel = 4'(FRAME_BITS-1) - idx_n;
   assign oDOUT_OE = (state == ACTIVE);

`ifdef ADC_RESP_PATTERN_EN
   logic [DATA_W-4:0] frame_cnt, frame_cnt_n;
   logic ch_data_unused;
   assign ch_data_unused = ^iCH_DATA;
   assign frame_cnt_n = frame_cnt + (DATA_W-3)'(commit);
   assign load_word = {load_ch, frame_cnt_n};
   always_ff @(posedge iCLK or posedge iRST)
      if (iRST) frame_cnt <= '0;
      else frame_cnt <= frame_cnt_n;
`else
   assign load_word = (int'(load_ch) < N_CH) ? iCH_DATA[int'(load_ch)*DATA_W +: DATA_W] : '0;
`endif

   always_comb begin
      state_n = state;
      word_n = word;
      addr_sh_n = addr_sh;
      ch_n = oCH;
      addr_next_n = oADDR_NEXT;
      dout_n = oDOUT;
      if (cs_rise) begin
         state_n = IDLE;
         dout_n = 1'b0;
         addr_sh_n = '0;
      end else if (start) begin
         state_n = ACTIVE;
         ch_n = '0;
         word_n = load_word;
         dout_n = 1'b0;
         addr_sh_n = '0;
      end else if (state == ACTIVE && sclk_fall) begin
         dout_n = (idx_n < 4'(LEAD_ZEROS)) ? 1'b0 : word[bit_sel];
      end else if (state == ACTIVE && sclk_rise) begin
         if (idx >= 4'(ADDR_LO_IDX) && idx <= 4'(ADDR_HI_IDX)) addr_sh_n = {addr_sh[ADDR_W-2:0], din_s};
         if (commit) begin
            addr_next_n = addr_sh;
            ch_n = addr_sh;
            word_n = load_word;
            addr_sh_n = '0;
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST)
      if (iRST) begin
         state <= IDLE;
         idx <= '0;
         word <= '0;
         addr_sh <= '0;
         oCH <= '0;
         oADDR_NEXT <= '0;
         oDOUT <= 1'b0;
         oFRAME_DONE <= 1'b0;
      end else begin
         state <= state_n;
         idx <= start ? 4'd0 : (state == ACTIVE && !cs_rise && sclk_fall) ? idx_n : idx;
         word <= word_n;
         addr_sh <= addr_sh_n;
         oCH <= ch_n;
         oADDR_NEXT <= addr_next_n;
         oDOUT <= dout_n;
         oFRAME_DONE <= commit;
      end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: scoreboard bench acting as the SPI master for adc_spi_responder.
module tb_adc_spi_responder;
   logic iCLK = 1'b0, iRST = 1'b1, iCS_n = 1'b1, iSCLK = 1'b1, iDIN = 1'b0;
   logic [95:0] iCH_DATA;
   logic oDOUT, oDOUT_OE, oFRAME_DONE;
   logic [2:0] oCH, oADDR_NEXT;
   logic [11:0] ch_data [8];
   logic [11:0] exp_q [$];
   logic [2:0] cur_ch = '0;
   int n_chk = 0, n_pass = 0, done_cnt = 0, frames = 0;

   adc_spi_responder dut (
      .iCLK(iCLK), .iRST(iRST), .iCS_n(iCS_n), .iSCLK(iSCLK), .iDIN(iDIN), .iCH_DATA(iCH_DATA),
      .oDOUT(oDOUT), .oDOUT_OE(oDOUT_OE), .oFRAME_DONE(oFRAME_DONE), .oCH(oCH), .oADDR_NEXT(oADDR_NEXT));

   always #5 iCLK = ~iCLK;

   always_comb begin
      iCH_DATA = '0;
      for (int k = 0; k < 8; k++) iCH_DATA[k*12 +: 12] = ch_data[k];
   end

   always @(negedge iCLK) if (oFRAME_DONE) done_cnt++;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic pulse(input logic d, output logic s);
      s = oDOUT;
      iSCLK = 1'b0;
      iDIN = d;
      repeat (5) @(negedge iCLK);
      iSCLK = 1'b1;
      repeat (5) @(negedge iCLK);
   endtask

   function automatic logic [11:0] model_word(input logic [2:0] ch);
`ifdef ADC_RESP_PATTERN_EN
      return {ch, 9'(frames)};
`else
      return ch_data[ch];
`endif
   endfunction

   task automatic cs_low();
      iCS_n = 1'b0;
      cur_ch = '0;
      repeat (5) @(negedge iCLK);
   endtask

   task automatic cs_high();
      iCS_n = 1'b1;
      repeat (5) @(negedge iCLK);
   endtask

   task automatic frame(input logic [2:0] addr, input int n, input bit tear);
      logic [15:0] bits;
      logic s;
      int d0;
      bits = '0;
      d0 = done_cnt;
      exp_q.push_back(model_word(cur_ch));
      check("oe_active", oDOUT_OE, 1);
      check("ch", oCH, cur_ch);
      for (int p = 1; p <= n; p++) begin
         pulse((p >= 3 && p <= 5) ? addr[5-p] : 1'b0, s);
         bits = {bits[14:0], s};
         if (tear && p == 7) ch_data[0] = 12'h800;
      end
      if (n == 16) begin
         check("word", bits, {4'h0, exp_q.pop_front()});
         check("done_pulses", done_cnt - d0, 1);
         check("addr_next", oADDR_NEXT, addr);
         frames++;
         cur_ch = addr;
      end else begin
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      int d0;
      logic s;
      foreach (ch_data[k]) ch_data[k] = '0;
      repeat (3) @(negedge iCLK);
      check("reset_outputs", {oDOUT, oDOUT_OE, oFRAME_DONE, oCH, oADDR_NEXT}, 0);
      iRST = 1'b0;
      repeat (5) @(negedge iCLK);
`ifdef ADC_RESP_PATTERN_EN
      cs_low();
      frame(3'd3, 16, 1'b0);
      frame(3'd3, 16, 1'b0);
      frame(3'd3, 16, 1'b0);
      cs_high();
`else
      ch_data[0] = 12'hA5C;
      cs_low();
      frame(3'd0, 16, 1'b0);
      cs_high();
      check("oe_idle", oDOUT_OE, 0);
      // SCLK activity with CS high must be ignored.
      d0 = done_cnt;
      repeat (20) pulse(1'b1, s);
      check("idle_no_done", done_cnt - d0, 0);
      check("idle_dout", oDOUT, 0);
      ch_data[5] = 12'h123;
      ch_data[2] = 12'hFFF;
      ch_data[7] = 12'h001;
      ch_data[6] = 12'h3C3;
      cs_low();
      frame(3'd5, 16, 1'b0);
      frame(3'd2, 16, 1'b0);
      frame(3'd7, 16, 1'b0);
      frame(3'd6, 16, 1'b0);
      frame(3'd0, 16, 1'b0);
      cs_high();
      cs_low();
      frame(3'd1, 16, 1'b0);
      cs_high();
      d0 = done_cnt;
      cs_low();
      frame(3'd3, 9, 1'b0);
      iCS_n = 1'b1;
      repeat (3) @(negedge iCLK);
      check("abort_oe", oDOUT_OE, 0);
      repeat (10) @(negedge iCLK);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_addr_kept", oADDR_NEXT, 3'd1);
      cs_low();
      frame(3'd0, 16, 1'b0);
      cs_high();
      ch_data[0] = 12'h0F0;
      cs_low();
      frame(3'd4, 16, 1'b1);
      frame(3'd4, 16, 1'b0);
      frame(3'd0, 16, 1'b0);
      cs_high();
      ch_data[0] = 12'h5A3;
      ch_data[4] = 12'h9E1;
      cs_low();
      frame(3'd4, 16, 1'b0);
      frame(3'd1, 10, 1'b0);
      iRST = 1'b1;
      #1;
      check("reset_midframe", {oDOUT, oDOUT_OE, oFRAME_DONE, oCH, oADDR_NEXT}, 0);
      @(negedge iCLK);
      @(negedge iCLK);
      iRST = 1'b0;
      frames = 0;
      repeat (5) @(negedge iCLK);
      d0 = done_cnt;
      repeat (16) pulse(1'b0, s);
      check("no_resume_oe", oDOUT_OE, 0);
      check("no_resume_done", done_cnt - d0, 0);
      cs_high();
      cs_low();
      frame(3'd0, 16, 1'b0);
      cs_high();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
